// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : systolic_pkg
// Description : Shared definitions for the systolic operand loader.
//               Holds the default operand widths, the serial frame length and
//               the loader state encoding.
//               Optional feature macro: SYSTOLIC_LOADER_PARITY_EN adds one
//               trailing even-parity bit to every frame.
// Revision    : 1.0 - initial release
// ============================================================================
package systolic_pkg;

    localparam int DEF_ROW    = 4;
    localparam int DEF_COLUMN = 11;

    // Serial frame length for a given operand geometry.
    function automatic int frameLen(input int row, input int column);
`ifdef SYSTOLIC_LOADER_PARITY_EN
        return row + column + 1;
`else
        return row + column;
`endif
    endfunction

    localparam int FRAME_LEN = frameLen(DEF_ROW, DEF_COLUMN);

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_PRESENT = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/systolic_shift_in.sv
`default_nettype none
// ============================================================================
// Module      : systolic_shift_in
// Description : Serial-to-parallel shadow register and frame bit counter.
//               Bits arrive LSB first. The final bit of a frame is not stored;
//               it is presented combinationally on o_frame alongside the
//               shadow so the parent can apply the whole frame on the very
//               edge that accepts it.
// Ports       : clk         - clock
//               rst         - synchronous active-high reset
//               i_accept    - a serial bit is being accepted this cycle
//               i_data      - serial bit value
//               o_frameDone - this accept completes the frame
//               o_frame     - full frame (current bit in the MSB)
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_shift_in #(
    parameter int FRAME_W = 15,
    parameter int CNT_W   = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_accept,
    input  logic               i_data,
    output logic               o_frameDone,
    output logic [FRAME_W-1:0] o_frame
);

    logic [FRAME_W-2:0] r_shadow;
    logic [CNT_W-1:0]   r_bitCnt;
    logic               w_lastBit;

    assign w_lastBit   = (r_bitCnt == CNT_W'(FRAME_W - 1));
    assign o_frameDone = i_accept & w_lastBit;
    // Right shift with the new bit entering the top: after FRAME_W-1 accepts
    // bit 0 of the stream sits at index 0.
    assign o_frame     = {i_data, r_shadow};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow <= '0;
            r_bitCnt <= '0;
        end else if (i_accept) begin
            r_shadow <= {i_data, r_shadow[FRAME_W-2:1]};
            r_bitCnt <= w_lastBit ? '0 : r_bitCnt + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/systolic_operand_loader.sv
`default_nettype none
// ============================================================================
// Module      : systolic_operand_loader
// Description : Loads a serial LSB-first frame into registered row/column
//               operands for a systolic array, waits SETTLE cycles, samples
//               the array's combinational result and offers it on a
//               valid/ready result port.
//               Optional feature macro: SYSTOLIC_LOADER_PARITY_EN - frames
//               carry a trailing even-parity bit; a failing frame leaves the
//               operands untouched and reports res_err=1, res_data=0.
// Ports       : clk, reset           - clock, synchronous active-high reset
//               s_valid/s_data/s_ready - serial operand input handshake
//               inRow, inColumn      - registered operands to the array
//               array_out            - combinational array result
//               res_valid/res_data/res_err/res_ready - result handshake
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_operand_loader
    import systolic_pkg::*;
#(
    parameter int ROW    = DEF_ROW,
    parameter int COLUMN = DEF_COLUMN,
    parameter int SETTLE = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    input  logic              s_data,
    output logic              s_ready,
    output logic [ROW-1:0]    inRow,
    output logic [COLUMN-1:0] inColumn,
    input  logic              array_out,
    output logic              res_valid,
    output logic              res_data,
    output logic              res_err,
    input  logic              res_ready
);

    localparam int FRAME_W  = frameLen(ROW, COLUMN);
    localparam int CNT_W    = $clog2(ROW + COLUMN + 2);
    localparam int SETTLE_W = 4;

    state_e               r_state;
    state_e               w_stateNext;
    logic                 r_sReady;
    logic [SETTLE_W-1:0]  r_settleCnt;
    logic [ROW-1:0]       r_inRow;
    logic [COLUMN-1:0]    r_inColumn;
    logic                 r_parErr;
    logic                 r_resData;
    logic                 r_resErr;

    logic                 w_accept;
    logic                 w_frameDone;
    logic [FRAME_W-1:0]   w_frame;
    logic                 w_parityOk;
    logic                 w_settleDone;

    assign w_accept     = s_valid & r_sReady;
    assign w_settleDone = (r_settleCnt == SETTLE_W'(SETTLE - 1));

`ifdef SYSTOLIC_LOADER_PARITY_EN
    // Even parity across payload plus parity bit must reduce to zero.
    assign w_parityOk = ~(^w_frame);
`else
    assign w_parityOk = 1'b1;
`endif

    systolic_shift_in #(
        .FRAME_W (FRAME_W),
        .CNT_W   (CNT_W)
    ) u_shiftIn (
        .clk         (clk),
        .rst         (reset),
        .i_accept    (w_accept),
        .i_data      (s_data),
        .o_frameDone (w_frameDone),
        .o_frame     (w_frame)
    );

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_LOAD: begin
                if (w_frameDone) w_stateNext = ST_SETTLE;
            end
            ST_SETTLE: begin
                // A parity failure spends exactly one cycle here.
                if (r_parErr || w_settleDone) w_stateNext = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (res_ready) w_stateNext = ST_LOAD;
            end
            default: w_stateNext = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_LOAD;
            r_sReady    <= 1'b0;
            r_settleCnt <= '0;
            r_inRow     <= '0;
            r_inColumn  <= '0;
            r_parErr    <= 1'b0;
            r_resData   <= 1'b0;
            r_resErr    <= 1'b0;
        end else begin
            r_state  <= w_stateNext;
            // Registered so it stays low through reset and rises on the
            // first edge after release.
            r_sReady <= (w_stateNext == ST_LOAD);

            if (r_state == ST_SETTLE && w_stateNext == ST_SETTLE) begin
                r_settleCnt <= r_settleCnt + SETTLE_W'(1);
            end else begin
                r_settleCnt <= '0;
            end

            if (w_frameDone) begin
                r_parErr <= ~w_parityOk;
                if (w_parityOk) begin
                    r_inRow    <= w_frame[ROW-1:0];
                    r_inColumn <= w_frame[ROW +: COLUMN];
                end
            end

            if (r_state == ST_SETTLE && w_stateNext == ST_PRESENT) begin
                r_resData <= r_parErr ? 1'b0 : array_out;
                r_resErr  <= r_parErr;
            end
        end
    end

    assign s_ready   = r_sReady;
    assign inRow     = r_inRow;
    assign inColumn  = r_inColumn;
    assign res_valid = (r_state == ST_PRESENT);
    assign res_data  = r_resData;
    assign res_err   = r_resErr;

endmodule
`default_nettype wire
